// File: rtl/frontend_pkg.sv
// Shared types and constants for the instruction-fetch frontend: queue entry,
// BTB entry and the 2-bit branch counter helpers.
package frontend_pkg;

  localparam int         FE_XLEN     = 32;
  localparam int         INSTR_BYTES = 4;
  localparam logic [1:0] CTR_RESET   = 2'b01;
  localparam logic [1:0] CTR_ALLOC   = 2'b10;
  localparam logic [1:0] CTR_MAX     = 2'b11;
  localparam logic [1:0] CTR_MIN     = 2'b00;

  typedef struct packed {
    logic [FE_XLEN-1:0] pc;
    logic [FE_XLEN-1:0] instr;
    logic               pred_taken;
    logic [FE_XLEN-1:0] pred_target;
  } fetch_entry_t;

  // The tag field is sized for the widest tag; narrower tags are zero-extended.
  typedef struct packed {
    logic               valid;
    logic [FE_XLEN-1:0] tag;
    logic [FE_XLEN-1:0] target;
    logic [1:0]         ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_sat_inc(input logic [1:0] ctr);
    logic [1:0] res;
    case (ctr)
      CTR_MAX: res = CTR_MAX;
      default: res = ctr + 2'd1;
    endcase
    return res;
  endfunction

  function automatic logic [1:0] ctr_sat_dec(input logic [1:0] ctr);
    logic [1:0] res;
    case (ctr)
      CTR_MIN: res = CTR_MIN;
      default: res = ctr - 2'd1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/frontend_fetch_queue_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC and
// single-port training from resolved branches (writes visible next cycle).
module frontend_btb
  import frontend_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  btb_entry_t btb_r [BTB_ENTRIES];

  logic [IDX-1:0]   lk_idx_s;
  logic [IDX-1:0]   up_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic [TAG_W-1:0] up_tag_s;
  btb_entry_t       lk_entry_s;
  btb_entry_t       up_entry_s;
  btb_entry_t       up_next_s;
  logic             up_hit_s;
  logic             up_we_s;
  logic             unused_s;

  assign lk_idx_s   = lookup_pc[IDX+1:2];
  assign lk_tag_s   = lookup_pc[XLEN-1:IDX+2];
  assign up_idx_s   = upd_pc[IDX+1:2];
  assign up_tag_s   = upd_pc[XLEN-1:IDX+2];
  assign unused_s   = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lk_entry_s  = btb_r[lk_idx_s];
  assign pred_taken  = lk_entry_s.valid && (lk_entry_s.tag == FE_XLEN'(lk_tag_s)) && lk_entry_s.ctr[1];
  assign pred_target = XLEN'(lk_entry_s.target);

  assign up_entry_s = btb_r[up_idx_s];
  assign up_hit_s   = up_entry_s.valid && (up_entry_s.tag == FE_XLEN'(up_tag_s));

  // Training: reinforce/retarget on hit, allocate on taken miss, ignore not-taken miss.
  always_comb begin
    up_next_s = up_entry_s;
    up_we_s   = 1'b0;
    if (upd_valid) begin
      if (upd_taken) begin
        up_we_s          = 1'b1;
        up_next_s.target = FE_XLEN'(upd_target);
        if (up_hit_s) begin
          up_next_s.ctr = ctr_sat_inc(up_entry_s.ctr);
        end else begin
          up_next_s.valid = 1'b1;
          up_next_s.tag   = FE_XLEN'(up_tag_s);
          up_next_s.ctr   = CTR_ALLOC;
        end
      end else if (up_hit_s) begin
        up_we_s       = 1'b1;
        up_next_s.ctr = ctr_sat_dec(up_entry_s.ctr);
      end else begin
        up_we_s = 1'b0;
      end
    end else begin
      up_we_s = 1'b0;
    end
  end

  // BTB storage with async clear of every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_r[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
      end
    end else if (up_we_s) begin
      btb_r[up_idx_s] <= up_next_s;
    end
  end

endmodule

// File: rtl/frontend_fetch_queue.sv
// Fetch stage: fetch PC register, BTB-predicted next PC, and a circular fetch
// queue feeding decode, with execute redirects flushing everything in flight.
module frontend_fetch_queue
  import frontend_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              DEPTH       = 4,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [XLEN-1:0]            iaddr,
  input  logic [XLEN-1:0]            idata,
  input  logic                       imem_valid,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_instr,
  output logic                       out_pred_taken,
  output logic [XLEN-1:0]            out_pred_target,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       upd_valid,
  input  logic                       upd_taken,
  input  logic [XLEN-1:0]            upd_pc,
  input  logic [XLEN-1:0]            upd_target,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int                PTR_W     = $clog2(DEPTH);
  localparam int                CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [XLEN-1:0]   RESET_FPC = {RESET_PC[XLEN-1:2], 2'b00};

  fetch_entry_t queue_r [DEPTH];

  logic [XLEN-1:0]  fpc_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             out_valid_s;
  logic             pop_s;
  logic             fetch_s;
  logic             pred_taken_s;
  logic [XLEN-1:0]  pred_target_s;
  logic [XLEN-1:0]  next_pc_s;
  fetch_entry_t     push_entry_s;
  fetch_entry_t     head_s;
  logic             unused_s;

  frontend_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .reset       (reset),
    .lookup_pc   (fpc_r),
    .pred_taken  (pred_taken_s),
    .pred_target (pred_target_s),
    .upd_valid   (upd_valid),
    .upd_taken   (upd_taken),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target)
  );

  assign unused_s    = ^{redirect_pc[1:0], pred_target_s[1:0]};
  assign out_valid_s = (count_r != '0) && !redirect_valid;
  assign pop_s       = out_valid_s && out_ready;
  // A full queue can still accept a fetch when decode drains the head this cycle.
  assign fetch_s     = imem_valid && !redirect_valid && ((count_r != FULL_CNT) || pop_s);
  assign next_pc_s   = pred_taken_s ? {pred_target_s[XLEN-1:2], 2'b00}
                                    : fpc_r + XLEN'(INSTR_BYTES);

  assign push_entry_s = '{pc:          FE_XLEN'(fpc_r),
                          instr:       FE_XLEN'(idata),
                          pred_taken:  pred_taken_s,
                          pred_target: FE_XLEN'(pred_target_s)};

  assign head_s          = queue_r[rd_ptr_r];
  assign iaddr           = fpc_r;
  assign out_valid       = out_valid_s;
  assign out_pc          = XLEN'(head_s.pc);
  assign out_instr       = XLEN'(head_s.instr);
  assign out_pred_taken  = head_s.pred_taken;
  assign out_pred_target = XLEN'(head_s.pred_target);
  assign count           = count_r;

  // Occupancy update for push/pop combinations.
  always_comb begin
    count_nxt_s = count_r;
    case ({fetch_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Fetch PC, pointers and occupancy; redirect overrides any push or pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_r    <= RESET_FPC;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (redirect_valid) begin
      fpc_r    <= {redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (fetch_s) begin
        fpc_r    <= next_pc_s;
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  // Queue payload storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (fetch_s) begin
      queue_r[wr_ptr_r] <= push_entry_s;
    end
  end

endmodule

// File: tb/tb_frontend_fetch_queue.sv
// Directed self-checking bench for frontend_fetch_queue: sequential fetch,
// full-queue pop/push, redirect flush, BTB training/aliasing and reset.
module tb_frontend_fetch_queue;

  logic        clk;
  logic        reset;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        imem_valid;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_pred_taken;
  logic [31:0] out_pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic        upd_taken;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  frontend_fetch_queue dut (
    .clk             (clk),
    .reset           (reset),
    .iaddr           (iaddr),
    .idata           (idata),
    .imem_valid      (imem_valid),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .out_pred_taken  (out_pred_taken),
    .out_pred_target (out_pred_target),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .upd_valid       (upd_valid),
    .upd_taken       (upd_taken),
    .upd_pc          (upd_pc),
    .upd_target      (upd_target),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  // Instruction memory answers combinationally for the current fetch address.
  assign idata = instr_of(iaddr);

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic fetch_one;
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
  endtask

  task automatic btb_update(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
    upd_valid  = 1'b1;
    upd_taken  = taken;
    upd_pc     = pc;
    upd_target = tgt;
    tick();
    upd_valid  = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) tick();
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr: got %h expected 00000000", iaddr); end
    reset = 1'b0;
    tick();
    checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL reset_idle_iaddr: got %h expected 00000000", iaddr); end
  endtask

  task automatic test_sequential_fetch;
    imem_valid = 1'b1;
    out_ready  = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL seq_empty_valid: got %b expected 0", out_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL seq_count[%0d]: got %0d expected %0d", i, count, i + 1); end
      checks++; if (iaddr !== 32'(4 * (i + 1))) begin errors++; $display("FAIL seq_iaddr[%0d]: got %h expected %h", i, iaddr, 4 * (i + 1)); end
    end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL seq_head_pc: got %h expected 00000000", out_pc); end
    checks++; if (out_instr !== instr_of(32'h0)) begin errors++; $display("FAIL seq_head_instr: got %h expected %h", out_instr, instr_of(32'h0)); end
    tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL seq_full_count: got %0d expected 4", count); end
    checks++; if (iaddr !== 32'h10) begin errors++; $display("FAIL seq_full_hold: got %h expected 00000010", iaddr); end
  endtask

  task automatic test_full_pop;
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b expected 1", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL full_head_pc: got %h expected 00000000", out_pc); end
    tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_pushpop_count: got %0d expected 4", count); end
    checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL full_next_head: got %h expected 00000004", out_pc); end
    checks++; if (iaddr !== 32'h14) begin errors++; $display("FAIL full_iaddr: got %h expected 00000014", iaddr); end
    out_ready  = 1'b0;
    imem_valid = 1'b0;
  endtask

  task automatic test_redirect;
    out_ready = 1'b1;
    tick();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL stall_pop_count: got %0d expected 3", count); end
    checks++; if (iaddr !== 32'h14) begin errors++; $display("FAIL stall_iaddr: got %h expected 00000014", iaddr); end
    checks++; if (out_pc !== 32'h8) begin errors++; $display("FAIL stall_head: got %h expected 00000008", out_pc); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    imem_valid     = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_out_valid: got %b expected 0", out_valid); end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL redir_count: got %0d expected 0", count); end
    checks++; if (iaddr !== 32'h200) begin errors++; $display("FAIL redir_iaddr: got %h expected 00000200", iaddr); end
    redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h404;
    tick();
    checks++; if (iaddr !== 32'h404) begin errors++; $display("FAIL redir_last_wins: got %h expected 00000404", iaddr); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL redir_chain_count: got %0d expected 0", count); end
    redirect_valid = 1'b0;
    imem_valid     = 1'b0;
    out_ready      = 1'b0;
  endtask

  task automatic test_btb_train;
    btb_update(32'h40, 32'h100, 1'b1);
    do_redirect(32'h40);
    fetch_one();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL train_count: got %0d expected 1", count); end
    checks++; if (out_pc !== 32'h40) begin errors++; $display("FAIL train_pc: got %h expected 00000040", out_pc); end
    checks++; if (out_pred_taken !== 1'b1) begin errors++; $display("FAIL train_taken: got %b expected 1", out_pred_taken); end
    checks++; if (out_pred_target !== 32'h100) begin errors++; $display("FAIL train_target: got %h expected 00000100", out_pred_target); end
    checks++; if (iaddr !== 32'h100) begin errors++; $display("FAIL train_iaddr: got %h expected 00000100", iaddr); end
    // 0x80 shares the index of 0x40 with a different tag.
    do_redirect(32'h80);
    fetch_one();
    checks++; if (out_pred_taken !== 1'b0) begin errors++; $display("FAIL alias_taken: got %b expected 0", out_pred_taken); end
    checks++; if (iaddr !== 32'h84) begin errors++; $display("FAIL alias_iaddr: got %h expected 00000084", iaddr); end
    btb_update(32'h80, 32'h999, 1'b0);
    do_redirect(32'h40);
    fetch_one();
    checks++; if (iaddr !== 32'h100) begin errors++; $display("FAIL nt_miss_nochange: got %h expected 00000100", iaddr); end
    btb_update(32'h40, 32'h0, 1'b0);
    btb_update(32'h40, 32'h0, 1'b0);
    do_redirect(32'h40);
    fetch_one();
    checks++; if (out_pred_taken !== 1'b0) begin errors++; $display("FAIL untrain_taken: got %b expected 0", out_pred_taken); end
    checks++; if (iaddr !== 32'h44) begin errors++; $display("FAIL untrain_iaddr: got %h expected 00000044", iaddr); end
  endtask

  task automatic test_btb_saturate;
    // Counter is 0 here: one taken hit must only step to 1, not re-allocate.
    btb_update(32'h40, 32'h140, 1'b1);
    do_redirect(32'h40);
    fetch_one();
    checks++; if (iaddr !== 32'h44) begin errors++; $display("FAIL sat_ctr1_iaddr: got %h expected 00000044", iaddr); end
    btb_update(32'h40, 32'h140, 1'b1);
    do_redirect(32'h40);
    fetch_one();
    checks++; if (iaddr !== 32'h140) begin errors++; $display("FAIL sat_ctr2_iaddr: got %h expected 00000140", iaddr); end
    btb_update(32'h40, 32'h140, 1'b1);
    btb_update(32'h40, 32'h140, 1'b1);
    btb_update(32'h40, 32'h140, 1'b0);
    do_redirect(32'h40);
    fetch_one();
    checks++; if (out_pred_taken !== 1'b1) begin errors++; $display("FAIL sat_max_taken: got %b expected 1", out_pred_taken); end
    checks++; if (iaddr !== 32'h140) begin errors++; $display("FAIL sat_max_iaddr: got %h expected 00000140", iaddr); end
  endtask

  task automatic test_same_cycle_update;
    do_redirect(32'h48);
    imem_valid = 1'b1;
    upd_valid  = 1'b1;
    upd_taken  = 1'b1;
    upd_pc     = 32'h48;
    upd_target = 32'h200;
    tick();
    imem_valid = 1'b0;
    upd_valid  = 1'b0;
    checks++; if (out_pred_taken !== 1'b0) begin errors++; $display("FAIL same_cycle_taken: got %b expected 0", out_pred_taken); end
    checks++; if (iaddr !== 32'h4C) begin errors++; $display("FAIL same_cycle_iaddr: got %h expected 0000004c", iaddr); end
    do_redirect(32'h48);
    fetch_one();
    checks++; if (out_pred_target !== 32'h200) begin errors++; $display("FAIL after_update_target: got %h expected 00000200", out_pred_target); end
    checks++; if (iaddr !== 32'h200) begin errors++; $display("FAIL after_update_iaddr: got %h expected 00000200", iaddr); end
  endtask

  task automatic test_back_to_back;
    do_redirect(32'h500);
    out_ready  = 1'b1;
    imem_valid = 1'b1;
    tick();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_first_count: got %0d expected 1", count); end
    checks++; if (out_pc !== 32'h500) begin errors++; $display("FAIL b2b_first_pc: got %h expected 00000500", out_pc); end
    for (int k = 1; k < 8; k++) begin
      tick();
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 1", k, count); end
      checks++; if (out_pc !== 32'h500 + 32'(4 * k)) begin errors++; $display("FAIL b2b_pc[%0d]: got %h expected %h", k, out_pc, 32'h500 + 32'(4 * k)); end
      checks++; if (out_instr !== instr_of(32'h500 + 32'(4 * k))) begin errors++; $display("FAIL b2b_instr[%0d]: got %h expected %h", k, out_instr, instr_of(32'h500 + 32'(4 * k))); end
    end
    imem_valid = 1'b0;
    out_ready  = 1'b0;
  endtask

  task automatic test_reset_midop;
    do_redirect(32'h600);
    imem_valid = 1'b1;
    tick();
    tick();
    imem_valid = 1'b0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL midrst_pre_count: got %0d expected 2", count); end
    reset = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL midrst_iaddr: got %h expected 00000000", iaddr); end
    tick();
    reset      = 1'b0;
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL postrst_count: got %0d expected 1", count); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL postrst_pc: got %h expected 00000000", out_pc); end
    do_redirect(32'h48);
    fetch_one();
    checks++; if (out_pred_taken !== 1'b0) begin errors++; $display("FAIL postrst_btb_taken: got %b expected 0", out_pred_taken); end
    checks++; if (iaddr !== 32'h4C) begin errors++; $display("FAIL postrst_btb_iaddr: got %h expected 0000004c", iaddr); end
  endtask

  initial begin
    reset          = 1'b1;
    imem_valid     = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    upd_valid      = 1'b0;
    upd_taken      = 1'b0;
    upd_pc         = 32'h0;
    upd_target     = 32'h0;
    test_reset();
    test_sequential_fetch();
    test_full_pop();
    test_redirect();
    test_btb_train();
    test_btb_saturate();
    test_same_cycle_update();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
